// File: rtl/fir_param_engine_if.sv
// Memory-side bus of the FIR block engine.
// Read port A (1-cycle latency) and write port B.
interface fir_param_engine_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]        mem_addr_a;
    logic                     mem_re_a;
    logic signed [DATA_W-1:0] mem_data_out_a;
    logic [ADDR_W-1:0]        mem_addr_b;
    logic signed [DATA_W-1:0] mem_data_in_b;
    logic                     mem_we_b;

    modport master (
        output mem_addr_a, mem_re_a,
        input  mem_data_out_a,
        output mem_addr_b, mem_data_in_b, mem_we_b
    );

    modport slave (
        input  mem_addr_a, mem_re_a,
        output mem_data_out_a,
        input  mem_addr_b, mem_data_in_b, mem_we_b
    );
endinterface

// File: rtl/fir_param_engine.sv
// Block FIR engine: streams sample_count samples from memory,
// filters them and writes results back at one sample per clock.
module fir_param_engine #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int TAPS      = 5,
    parameter int ADDR_W    = 10,
    parameter int OUT_SHIFT = 8,
    parameter int SAT_EN    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        input_addr,
    input  logic [ADDR_W-1:0]        output_addr,
    input  logic [ADDR_W-1:0]        sample_count,
    input  logic                     coef_we,
    input  logic [3:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     busy,
    output logic                     done,
    fir_param_engine_if.master       mem
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    // One guard bit so the rounding add never overflows.
    localparam int RW     = ACC_W + 1;

    localparam logic signed [RW-1:0] RND  =
        RW'((64'sd1 <<< OUT_SHIFT) >>> 1);
    localparam logic signed [RW-1:0] MAXV =
        RW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] in_base, out_base, cnt;
    logic [ADDR_W-1:0] rd_cnt, wr_cnt;

    logic signed [COEF_W-1:0] h    [TAPS];
    logic signed [DATA_W-1:0] x    [TAPS];
    logic signed [PROD_W-1:0] prod [TAPS];

    logic v0, v1, v2;
    logic accept, rd_fire;

    logic signed [ACC_W-1:0]  acc;
    logic signed [RW-1:0]     rnd, shf;
    logic signed [DATA_W-1:0] y;

    // Next-state and control decode.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        rd_fire  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_nx = DONE;
                end else begin
                    rd_fire = 1'b1;
                    if (rd_cnt == cnt - ADDR_W'(1))
                        state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (mem.mem_we_b && !v0 && !v1 && !v2)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Read port is driven straight from the issue decision.
    always_comb begin
        mem.mem_re_a   = rd_fire;
        mem.mem_addr_a = '0;
        if (rd_fire)
            mem.mem_addr_a = in_base + rd_cnt;
    end

    // State register, job parameters and read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_base  <= '0;
            out_base <= '0;
            cnt      <= '0;
            rd_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                in_base  <= input_addr;
                out_base <= output_addr;
                cnt      <= sample_count;
                rd_cnt   <= '0;
            end else if (rd_fire) begin
                rd_cnt <= rd_cnt + ADDR_W'(1);
            end
        end
    end

    // Coefficient bank, frozen while a block is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++)
                h[k] <= '0;
        end else if (coef_we && !busy) begin
            for (int k = 0; k < TAPS; k++)
                if (coef_idx == 4'(k))
                    h[k] <= coef_data;
        end
    end

    // Delay line shift and registered products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
            v2 <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x[k]    <= '0;
                prod[k] <= '0;
            end
        end else begin
            v0 <= rd_fire;
            v1 <= v0;
            v2 <= v1;
            if (accept) begin
                for (int k = 0; k < TAPS; k++)
                    x[k] <= '0;
            end else if (v0) begin
                x[0] <= mem.mem_data_out_a;
                for (int k = 1; k < TAPS; k++)
                    x[k] <= x[k-1];
            end
            if (v1) begin
                for (int k = 0; k < TAPS; k++)
                    prod[k] <= PROD_W'(h[k]) * PROD_W'(x[k]);
            end
        end
    end

    // Sum, round, shift and saturate/truncate.
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++)
            acc = acc + ACC_W'(prod[k]);
        rnd = RW'(acc) + RND;
        shf = rnd >>> OUT_SHIFT;
        y   = shf[DATA_W-1:0];
        if (SAT_EN != 0) begin
            if (shf > MAXV)
                y = MAXV[DATA_W-1:0];
            else if (shf < MINV)
                y = MINV[DATA_W-1:0];
        end
    end

    // Registered write port; address/data idle at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_we_b      <= 1'b0;
            mem.mem_addr_b    <= '0;
            mem.mem_data_in_b <= '0;
            wr_cnt            <= '0;
        end else begin
            mem.mem_we_b <= v2;
            if (accept)
                wr_cnt <= '0;
            if (v2) begin
                mem.mem_addr_b    <= out_base + wr_cnt;
                mem.mem_data_in_b <= y;
                wr_cnt            <= wr_cnt + ADDR_W'(1);
            end else begin
                mem.mem_addr_b    <= '0;
                mem.mem_data_in_b <= '0;
            end
        end
    end
endmodule
